match_sequencer: RTL and testbench
==================================

# match_sequencer

Match-level controller sitting above `game_controller`. It turns a player start button into a timed serve: counts down a fixed number of video frames, then issues the one-cycle `game_start` pulse to `game_controller`. It watches `game_over` to decrement lives, ends the match when lives run out, and keeps a best-score register. It drives the HUD outputs: countdown, lives, best score and match state.

## Interface
Parameters:
- `LIVES`, default 3: lives per match; legal range 1..7.
- `SERVE_FRAMES`, default 120: frame ticks of countdown before each serve; legal range 1..255.

Ports:
- `clk_25MHZ` input, 1: system clock; the only clock.
- `reset_n` input, 1: synchronous, active-low reset.
- `start_btn` input, 1: debounced level from the player button; edge-detected internally.
- `frame_tick` input, 1: one-cycle pulse per video frame (vsync).
- `game_over` input, 1: level from `game_controller`.
- `score` input, 8: current rally score from `game_controller`.
- `game_start` output, 1: one-cycle serve pulse to `game_controller`.
- `lives_left` output, 3: remaining lives.
- `countdown` output, 8: frames left before the serve.
- `best_score` output, 8: highest score seen since reset.
- `match_state` output, 2: 0 = IDLE, 1 = COUNTDOWN, 2 = PLAY, 3 = MATCH_OVER.
- `match_over` output, 1: high while in MATCH_OVER.

## Operation
Edge detection:
- Registers `start_d` and `go_d` follow `start_btn` and `game_over` every cycle, in every state.
- `start_rise` = `start_btn & ~start_d`.
- `go_rise` = `game_over & ~go_d`.

States and transitions:
- **IDLE**
  - On `start_rise`: go to COUNTDOWN, set `lives_left` = LIVES, set `countdown` = SERVE_FRAMES.
- **COUNTDOWN**
  - On `frame_tick` with `countdown` > 0: decrement `countdown`.
  - With `countdown` == 0: go to PLAY and register `game_start` = 1 for exactly one cycle.
  - `start_btn` is ignored.
- **PLAY**
  - On `go_rise`:
    - If BEST_SCORE_EN is defined and `score` > `best_score`: `best_score` <= `score`.
    - If `lives_left` == 1: `lives_left` <= 0 and go to MATCH_OVER.
    - Otherwise: `lives_left` decrements, `countdown` reloads to SERVE_FRAMES, go to COUNTDOWN.
  - `start_rise` is ignored.
- **MATCH_OVER**
  - On `start_rise`: reload lives and countdown as from IDLE, go to COUNTDOWN.
  - `best_score` is retained.

Arithmetic and registers:
- Arithmetic is unsigned.
- The score compare is 8-bit and strict: an equal score leaves `best_score` unchanged.
- `countdown` never underflows.
- All outputs are registered.

## Timing
Reset values (when `reset_n` = 0 at a clock edge):
- State = IDLE.
- `game_start` = 0, `lives_left` = 0, `countdown` = 0, `best_score` = 0, `match_over` = 0.
- `start_d` = 0, `go_d` = 0.
- A reset mid-countdown or mid-play aborts immediately. No `game_start` pulse is issued afterward until a new `start_rise` and a full countdown.

Latencies:
- A `start_rise` sampled at edge t gives `match_state` = COUNTDOWN and `countdown` = SERVE_FRAMES after edge t.
- `countdown` reaches 0 on the SERVE_FRAMES-th `frame_tick`.
- At the next edge, `game_start` = 1 and `match_state` = PLAY together. `game_start` drops on the following edge.
- A `go_rise` sampled at edge t updates `lives_left`, `best_score` and state after edge t.

Boundary conditions:
- `game_over` stays high from STOP until after the `game_start` pulse, because `game_controller` clears it one cycle after `game_start`. Since `go_d` = 1 at that point, entering PLAY never produces a false `go_rise`.
- A `frame_tick` arriving in the same cycle as the countdown reload is ignored; the reload wins.
- `start_btn` held high across a state change does not retrigger; a new rising edge is required.

## Configuration
- `MATCH_SEQUENCER_BEST_SCORE_EN` defined: the `best_score` register and compare are present, as described above.
- Not defined: no register or comparator is generated. `best_score` is tied to 8'd0, and `score` is unused.

## Test plan
All scenarios use LIVES=2 and SERVE_FRAMES=3.
- **Basic serve:** after reset, pulse `start_btn`, then give 3 `frame_tick`s.
  - Required: `countdown` steps 3→2→1→0.
  - Exactly one `game_start` cycle, coinciding with `match_state` = 2.
  - `lives_left` = 2.
- **Life loss:** in PLAY, raise `game_over` with `score` = 5.
  - Required: `lives_left` = 1, `best_score` = 5, `match_state` = 1, `countdown` = 3.
  - `game_over` held high through the countdown and re-serve gives no extra decrement.
- **Match over:** second `go_rise` with `score` = 4.
  - Required: `lives_left` = 0, `match_over` = 1, `best_score` stays 5.
  - A later `start_rise` reloads `lives_left` = 2 and `countdown` = 3.
- **Held button / mid-play start:** hold `start_btn` high through COUNTDOWN and PLAY.
  - Required: no retrigger; a new `start_rise` during PLAY does not change state.
- **Reset mid-countdown:** assert `reset_n` = 0 with `countdown` = 2.
  - Required: all outputs at reset values next cycle, and no `game_start` afterward.
- **Macro off:** repeat the life-loss scenario without `MATCH_SEQUENCER_BEST_SCORE_EN`.
  - Required: `best_score` = 0 throughout.

Source files
------------

// File: rtl/match_sequencer.sv
// Match-level serve/lives/best-score sequencer above game_controller.
// Define MATCH_SEQUENCER_BEST_SCORE_EN to build the best-score register.
module match_sequencer #(
  parameter int LIVES        = 3,
  parameter int SERVE_FRAMES = 120
) (
  input  logic       clk_25MHZ,
  input  logic       reset_n,
  input  logic       start_btn,
  input  logic       frame_tick,
  input  logic       game_over,
  input  logic [7:0] score,
  output logic       game_start,
  output logic [2:0] lives_left,
  output logic [7:0] countdown,
  output logic [7:0] best_score,
  output logic [1:0] match_state,
  output logic       match_over
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_PLAY  = 2'd2,
    S_OVER  = 2'd3
  } state_t;

  localparam logic [2:0] L_LIVES = 3'(LIVES);
  localparam logic [7:0] L_SERVE = 8'(SERVE_FRAMES);

  state_t     r_state;
  state_t     w_state_n;
  logic       r_start_d;
  logic       r_go_d;
  logic       r_game_start;
  logic       r_match_over;
  logic [2:0] r_lives;
  logic [7:0] r_cd;
  logic [2:0] w_lives_n;
  logic [7:0] w_cd_n;
  logic       w_gs_n;
  logic       w_start_rise;
  logic       w_go_rise;

  assign w_start_rise = start_btn & ~r_start_d;
  assign w_go_rise    = game_over & ~r_go_d;

  always_comb begin
    w_state_n = r_state;
    w_lives_n = r_lives;
    w_cd_n    = r_cd;
    w_gs_n    = 1'b0;
    unique case (r_state)
      S_IDLE, S_OVER: begin
        if (w_start_rise) begin
          w_state_n = S_COUNT;
          w_lives_n = L_LIVES;
          w_cd_n    = L_SERVE;
        end
      end
      S_COUNT: begin
        if (r_cd == 8'd0) begin
          w_state_n = S_PLAY;
          w_gs_n    = 1'b1;
        end else if (frame_tick) begin
          w_cd_n = r_cd - 8'd1;
        end
      end
      S_PLAY: begin
        if (w_go_rise) begin
          if (r_lives == 3'd1) begin
            w_lives_n = 3'd0;
            w_state_n = S_OVER;
          end else begin
            w_lives_n = r_lives - 3'd1;
            w_cd_n    = L_SERVE;
            w_state_n = S_COUNT;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_25MHZ) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_start_d    <= 1'b0;
      r_go_d       <= 1'b0;
      r_game_start <= 1'b0;
      r_match_over <= 1'b0;
      r_lives      <= 3'd0;
      r_cd         <= 8'd0;
    end else begin
      r_state      <= w_state_n;
      r_start_d    <= start_btn;
      r_go_d       <= game_over;
      r_game_start <= w_gs_n;
      r_match_over <= (w_state_n == S_OVER);
      r_lives      <= w_lives_n;
      r_cd         <= w_cd_n;
    end
  end

`ifdef MATCH_SEQUENCER_BEST_SCORE_EN
  logic [7:0] r_best;
  logic       w_best_ld;

  // Strict compare: a tie keeps the old best.
  assign w_best_ld = (r_state == S_PLAY) & w_go_rise
                   & (score > r_best);

  always_ff @(posedge clk_25MHZ) begin
    if (!reset_n) begin
      r_best <= 8'd0;
    end else if (w_best_ld) begin
      r_best <= score;
    end
  end

  assign best_score = r_best;
`else
  logic w_unused_score;
  assign w_unused_score = ^score;
  assign best_score     = 8'd0;
`endif

  assign game_start  = r_game_start;
  assign lives_left  = r_lives;
  assign countdown   = r_cd;
  assign match_state = r_state;
  assign match_over  = r_match_over;

endmodule

// File: tb/tb_match_sequencer.sv
// Scoreboard bench for match_sequencer with LIVES=2, SERVE_FRAMES=3.
// Expected best score follows MATCH_SEQUENCER_BEST_SCORE_EN.
module tb_match_sequencer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start_btn = 1'b0;
  logic       frame_tick = 1'b0;
  logic       game_over = 1'b0;
  logic [7:0] score = 8'd0;
  logic       game_start;
  logic [2:0] lives_left;
  logic [7:0] countdown;
  logic [7:0] best_score;
  logic [1:0] match_state;
  logic       match_over;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef MATCH_SEQUENCER_BEST_SCORE_EN
  localparam logic [7:0] B5 = 8'd5;
`else
  localparam logic [7:0] B5 = 8'd0;
`endif

  typedef struct {
    logic        rn;
    logic        st;
    logic        tk;
    logic        go;
    logic [7:0]  sc;
    logic [22:0] ex;
  } vec_t;

  logic [22:0] exp_q[$];

  match_sequencer #(
    .LIVES(2),
    .SERVE_FRAMES(3)
  ) dut (
    .clk_25MHZ(clk),
    .reset_n(reset_n),
    .start_btn(start_btn),
    .frame_tick(frame_tick),
    .game_over(game_over),
    .score(score),
    .game_start(game_start),
    .lives_left(lives_left),
    .countdown(countdown),
    .best_score(best_score),
    .match_state(match_state),
    .match_over(match_over)
  );

  always #20 clk = ~clk;

  function automatic logic [22:0] mk(
    input logic [1:0] st, input logic gs, input logic mo,
    input logic [2:0] lv, input logic [7:0] cd,
    input logic [7:0] bs);
    return {st, gs, mo, lv, cd, bs};
  endfunction

  function automatic vec_t sv(
    input logic rn, input logic st, input logic tk,
    input logic go, input logic [7:0] sc,
    input logic [22:0] ex);
    vec_t v;
    v.rn = rn; v.st = st; v.tk = tk;
    v.go = go; v.sc = sc; v.ex = ex;
    return v;
  endfunction

  function automatic logic [22:0] obs();
    return {match_state, game_start, match_over,
            lives_left, countdown, best_score};
  endfunction

  task automatic test_reset();
    vec_t v[$];
    logic [22:0] got;
    v.push_back(sv(0, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0)));
    v.push_back(sv(0, 1, 1, 1, 9, mk(0, 0, 0, 0, 0, 0)));
    foreach (v[i]) begin
      reset_n = v[i].rn; start_btn = v[i].st;
      frame_tick = v[i].tk; game_over = v[i].go;
      score = v[i].sc;
      exp_q.push_back(v[i].ex);
      @(posedge clk); #1;
      got = exp_q.pop_front();
      n_cmp++;
      if (obs() !== got) begin
        n_bad++;
        $display("FAIL reset[%0d] got=%h want=%h",
                 i, obs(), got);
      end
    end
  endtask

  task automatic test_basic_serve();
    vec_t v[$];
    logic [22:0] got;
    v.push_back(sv(1, 1, 0, 0, 0, mk(1, 0, 0, 2, 3, 0)));
    v.push_back(sv(1, 0, 0, 0, 0, mk(1, 0, 0, 2, 3, 0)));
    v.push_back(sv(1, 0, 1, 0, 0, mk(1, 0, 0, 2, 2, 0)));
    v.push_back(sv(1, 0, 1, 0, 0, mk(1, 0, 0, 2, 1, 0)));
    v.push_back(sv(1, 0, 1, 0, 0, mk(1, 0, 0, 2, 0, 0)));
    v.push_back(sv(1, 0, 0, 0, 0, mk(2, 1, 0, 2, 0, 0)));
    v.push_back(sv(1, 0, 0, 0, 0, mk(2, 0, 0, 2, 0, 0)));
    foreach (v[i]) begin
      reset_n = v[i].rn; start_btn = v[i].st;
      frame_tick = v[i].tk; game_over = v[i].go;
      score = v[i].sc;
      exp_q.push_back(v[i].ex);
      @(posedge clk); #1;
      got = exp_q.pop_front();
      n_cmp++;
      if (obs() !== got) begin
        n_bad++;
        $display("FAIL serve[%0d] got=%h want=%h",
                 i, obs(), got);
      end
    end
  endtask

  task automatic test_life_loss();
    vec_t v[$];
    logic [22:0] got;
    v.push_back(sv(1, 0, 0, 1, 5, mk(1, 0, 0, 1, 3, B5)));
    v.push_back(sv(1, 0, 1, 1, 5, mk(1, 0, 0, 1, 2, B5)));
    v.push_back(sv(1, 0, 1, 1, 5, mk(1, 0, 0, 1, 1, B5)));
    v.push_back(sv(1, 0, 1, 1, 5, mk(1, 0, 0, 1, 0, B5)));
    v.push_back(sv(1, 0, 0, 1, 5, mk(2, 1, 0, 1, 0, B5)));
    v.push_back(sv(1, 0, 0, 0, 5, mk(2, 0, 0, 1, 0, B5)));
    v.push_back(sv(1, 0, 0, 0, 5, mk(2, 0, 0, 1, 0, B5)));
    foreach (v[i]) begin
      reset_n = v[i].rn; start_btn = v[i].st;
      frame_tick = v[i].tk; game_over = v[i].go;
      score = v[i].sc;
      exp_q.push_back(v[i].ex);
      @(posedge clk); #1;
      got = exp_q.pop_front();
      n_cmp++;
      if (obs() !== got) begin
        n_bad++;
        $display("FAIL life[%0d] got=%h want=%h",
                 i, obs(), got);
      end
    end
  endtask

  task automatic test_match_over();
    vec_t v[$];
    logic [22:0] got;
    v.push_back(sv(1, 0, 0, 1, 4, mk(3, 0, 1, 0, 0, B5)));
    v.push_back(sv(1, 0, 1, 0, 4, mk(3, 0, 1, 0, 0, B5)));
    v.push_back(sv(1, 1, 0, 0, 4, mk(1, 0, 0, 2, 3, B5)));
    foreach (v[i]) begin
      reset_n = v[i].rn; start_btn = v[i].st;
      frame_tick = v[i].tk; game_over = v[i].go;
      score = v[i].sc;
      exp_q.push_back(v[i].ex);
      @(posedge clk); #1;
      got = exp_q.pop_front();
      n_cmp++;
      if (obs() !== got) begin
        n_bad++;
        $display("FAIL over[%0d] got=%h want=%h",
                 i, obs(), got);
      end
    end
  endtask

  task automatic test_held_button();
    vec_t v[$];
    logic [22:0] got;
    v.push_back(sv(1, 1, 1, 0, 0, mk(1, 0, 0, 2, 2, B5)));
    v.push_back(sv(1, 1, 1, 0, 0, mk(1, 0, 0, 2, 1, B5)));
    v.push_back(sv(1, 1, 1, 0, 0, mk(1, 0, 0, 2, 0, B5)));
    v.push_back(sv(1, 1, 0, 0, 0, mk(2, 1, 0, 2, 0, B5)));
    v.push_back(sv(1, 1, 0, 0, 0, mk(2, 0, 0, 2, 0, B5)));
    v.push_back(sv(1, 0, 0, 0, 0, mk(2, 0, 0, 2, 0, B5)));
    v.push_back(sv(1, 1, 1, 0, 0, mk(2, 0, 0, 2, 0, B5)));
    v.push_back(sv(1, 0, 0, 0, 0, mk(2, 0, 0, 2, 0, B5)));
    foreach (v[i]) begin
      reset_n = v[i].rn; start_btn = v[i].st;
      frame_tick = v[i].tk; game_over = v[i].go;
      score = v[i].sc;
      exp_q.push_back(v[i].ex);
      @(posedge clk); #1;
      got = exp_q.pop_front();
      n_cmp++;
      if (obs() !== got) begin
        n_bad++;
        $display("FAIL held[%0d] got=%h want=%h",
                 i, obs(), got);
      end
    end
  endtask

  task automatic test_reset_mid();
    vec_t v[$];
    logic [22:0] got;
    v.push_back(sv(1, 0, 0, 1, 5, mk(1, 0, 0, 1, 3, B5)));
    v.push_back(sv(1, 0, 1, 0, 5, mk(1, 0, 0, 1, 2, B5)));
    v.push_back(sv(0, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0)));
    for (int k = 0; k < 6; k++)
      v.push_back(sv(1, 0, 1, 0, 0, mk(0, 0, 0, 0, 0, 0)));
    foreach (v[i]) begin
      reset_n = v[i].rn; start_btn = v[i].st;
      frame_tick = v[i].tk; game_over = v[i].go;
      score = v[i].sc;
      exp_q.push_back(v[i].ex);
      @(posedge clk); #1;
      got = exp_q.pop_front();
      n_cmp++;
      if (obs() !== got) begin
        n_bad++;
        $display("FAIL rstmid[%0d] got=%h want=%h",
                 i, obs(), got);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_serve();
    test_life_loss();
    test_match_over();
    test_held_button();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
